// File: rtl/aes128_ks_sched_ctrl.sv
// rtl/aes128_ks_sched_ctrl.sv - AES-128 masked key-schedule sequencing controller
// Optional feature macro: AES_KS_RCON_REMASK_EN (adds rnd_rcon and masks RCON in every RUN cycle)
module aes128_ks_sched_ctrl #(
  parameter int d       = 2,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef AES_KS_RCON_REMASK_EN
  input  logic [8*(d-1)-1:0] rnd_rcon,
`endif
  output logic             busy,
  output logic             key_load,
  output logic             key_sel,
  output logic [8*d-1:0]   sh_RCON,
  output logic             rnd_en,
  output logic [3:0]       round,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             rk_last,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, HOLD, RUN} state_t;

  localparam logic [3:0] C_LAST = 4'(LATENCY - 1);

  state_t     state_q;
  logic [3:0] c_q;
  logic [7:0] rcon_q;
  logic [3:0] round_q;
  logic       busy_q;
  logic       rnd_en_q;
  logic       rk_valid_q;
  logic       rk_last_q;
  logic       done_q;
  logic [7:0] rcon_d;

  // GF(2^8) doubling used to step RCON from one round to the next
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  assign rcon_d = xtime(rcon_q);

  // Sequencer: IDLE -> HOLD (present key) -> RUN (LATENCY cycles) -> HOLD ... -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      c_q        <= 4'd0;
      rcon_q     <= 8'h01;
      round_q    <= 4'd0;
      busy_q     <= 1'b0;
      rnd_en_q   <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            round_q    <= 4'd0;
            rcon_q     <= 8'h01;
            state_q    <= HOLD;
            busy_q     <= 1'b1;
            rk_valid_q <= 1'b1;
            rk_last_q  <= 1'b0;
          end
        end
        HOLD: begin
          if (rk_ready) begin
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            if (round_q == 4'd10) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q  <= RUN;
              c_q      <= 4'd0;
              rnd_en_q <= 1'b1;
            end
          end
        end
        RUN: begin
          c_q <= c_q + 4'd1;
          if (c_q == C_LAST) begin
            round_q    <= round_q + 4'd1;
            rcon_q     <= rcon_d;
            state_q    <= HOLD;
            rnd_en_q   <= 1'b0;
            rk_valid_q <= 1'b1;
            rk_last_q  <= (round_q == 4'd9);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Key-register strobe/select and RCON shares are decoded in the cycle they are used
  always_comb begin
    key_load = 1'b0;
    key_sel  = 1'b0;
    sh_RCON  = '0;
    case (state_q)
      IDLE: key_load = start;
      RUN: begin
        if (c_q == C_LAST) begin
          key_load = 1'b1;
          key_sel  = 1'b1;
`ifndef AES_KS_RCON_REMASK_EN
          sh_RCON[7:0] = rcon_q;
`endif
        end
`ifdef AES_KS_RCON_REMASK_EN
        sh_RCON[7:0] = rcon_q;
        for (int i = 0; i < d - 1; i++) begin
          sh_RCON[7:0]           = sh_RCON[7:0] ^ rnd_rcon[8*i +: 8];
          sh_RCON[8*(i+1) +: 8]  = rnd_rcon[8*i +: 8];
        end
`endif
      end
      default: ;
    endcase
  end

  assign busy     = busy_q;
  assign rnd_en   = rnd_en_q;
  assign round    = round_q;
  assign rk_valid = rk_valid_q;
  assign rk_last  = rk_last_q;
  assign done     = done_q;

endmodule
